store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side counterpart of the load merge path. Takes a store request from the execute stage (SB, SH, SW, SWL, SWR) and builds the word-aligned address, byte enables and lane-shifted write data.
- Drives a single write transaction on the little-endian data bus. It holds the transaction until the bus stops stalling, then returns a one-cycle completion pulse to the CPU control path.
- Rejects misaligned SH/SW with a fault pulse instead of writing.

Parameters:
- WAIT_LIMIT, 0, maximum cycles to hold a write under waitrequest before aborting with a timeout fault; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle store request; sampled only in IDLE
- op  input  3  store_op_t: SB=0, SH=1, SW=2, SWL=3, SWR=4; other codes are illegal
- addr  input  32  byte address (rs + offset)
- rt_data  input  32  register value to store
- busy  output  1  high from the cycle after an accepted start until done/fault
- done  output  1  one-cycle pulse when the bus write completes
- fault  output  1  one-cycle pulse on misalignment, illegal op or timeout
- mem_address  output  32  {addr[31:2], 2'b00}
- mem_write  output  1  bus write strobe
- mem_byteenable  output  4  lane enables; bit i corresponds to byte addr+i, on writedata[8i+7:8i]
- mem_writedata  output  32  lane-positioned data; disabled lanes are driven 0
- mem_waitrequest  input  1  bus stall; a write completes in the first cycle mem_write=1 and waitrequest=0

Behaviour:
- Reset (async): state=IDLE. busy, done, fault, mem_write=0. mem_address, mem_byteenable, mem_writedata=0. Timeout counter=0.
- FSM states: IDLE, WRITE, RESP.
- IDLE:
  - start=1 with a legal, aligned request: register address, byteenable and writedata, go to WRITE.
  - start=1 with a misaligned or illegal request: go to RESP with fault set; no bus write.
  - start=0: stay in IDLE.
- Misaligned requests: SH with addr[0]=1; SW with addr[1:0]!=0. SWL, SWR and SB are never misaligned.
- WRITE:
  - mem_write=1 with all bus outputs stable.
  - waitrequest=0: go to RESP with done set.
  - waitrequest=1: stay in WRITE and increment the counter.
  - WAIT_LIMIT>0 and counter reaches WAIT_LIMIT while waitrequest=1: drop mem_write, go to RESP with fault set.
- RESP: done or fault high for exactly this cycle; clear the bus outputs; return to IDLE.
- Latency: start in cycle N; mem_write high from N+1; done in the cycle after the accepting edge. Minimum total is 3 cycles (start, write, resp).
- busy=1 in WRITE and RESP. A start while busy is ignored, not queued. busy is also 1 during a fault RESP.
- Lane mapping, with rt = {b3,b2,b1,b0} and o = addr[1:0]:
  - SB: be = 1<<o; byte b0 placed in lane o.
  - SH: o=0 gives be 0011, data {b1,b0} in lanes 1:0. o=2 gives be 1100, data {b1,b0} in lanes 3:2.
  - SW: be 1111, data = rt.
  - SWL:
    - o=0: be 0001, lanes = {0,0,0,b3}
    - o=1: be 0011, lanes = {0,0,b3,b2}
    - o=2: be 0111, lanes = {0,b3,b2,b1}
    - o=3: be 1111, lanes = rt
  - SWR:
    - o=0: be 1111, lanes = rt
    - o=1: be 1110, lanes = {b2,b1,b0,0}
    - o=2: be 1100, lanes = {b1,b0,0,0}
    - o=3: be 1000, lanes = {b0,0,0,0}
- Reset asserted mid-WRITE: mem_write drops immediately and asynchronously; no done or fault is produced.
- Inputs are sampled only at acceptance. Changes to op, addr or rt_data during WRITE have no effect.

Decomposition:
- Shared package (cpu_pkg): store_op_t enum and its code constants; byte-enable constants BE_NONE=4'b0000 and BE_ALL=4'b1111.
- One combinational sub-module, store_lane_align, computes byteenable, writedata and a misaligned flag from op, addr[1:0] and rt_data. It is the exact inverse of the load merge lane table. The top level holds the FSM, registers and timeout counter.

Test Plan:
- SWL, addr=0x1001, rt=0xAABBCCDD, waitrequest=0 -> mem_address=0x1000, be=0011, writedata=0x0000AABB, mem_write for 1 cycle, done pulse 2 cycles after start.
- SWR, addr=0x1002, rt=0xAABBCCDD -> be=1100, writedata=0xCCDD0000. Then SB at 0x1003 -> be=1000, writedata=0xDD000000. Then SH at 0x1002 -> be=1100, writedata=0xCCDD0000.
- SW, addr=0x1001 -> no mem_write, fault pulse 1 cycle after start, busy high for 1 cycle. Op code 7 -> same response.
- SW, addr=0x2000, waitrequest held high 3 cycles -> mem_write high for 4 cycles with all bus outputs stable, done on the cycle after waitrequest falls. A second start during busy -> ignored, no extra write.
- WAIT_LIMIT=4, waitrequest stuck high -> mem_write high for 4 cycles, then drops, fault pulse, done never asserted.
- Reset asserted mid-WRITE -> mem_write and all outputs 0 the same cycle (async). After release, state is IDLE and a new SWL at offset 3 gives be=1111, writedata=rt.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the store path: store opcodes, store FSM
// states and byte-enable constants.
package cpu_pkg;

   // Store operation codes as presented by the execute stage.
   typedef enum logic [2:0] {
      SB  = 3'd0,
      SH  = 3'd1,
      SW  = 3'd2,
      SWL = 3'd3,
      SWR = 3'd4
   } store_op_t;

   // Store unit control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      RESP  = 2'd2
   } store_state_t;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/store_unit_lane_align.sv
// Combinational lane aligner for stores. Maps a store op, the byte offset
// within the word and the register value onto little-endian bus lanes.
// It is the inverse of the load merge table: SWL writes the upper
// register bytes into the low lanes up to the addressed byte, and SWR
// writes the low register bytes from the addressed byte upward.
module store_lane_align
   import cpu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] rt_data,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic        misaligned,
   output logic        illegal
);

   // Lane selection per opcode; rejected requests enable no lanes.
   always_comb begin
      byteenable = BE_NONE;
      writedata  = 32'd0;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (store_op_t'(op))
         SB: begin
            byteenable = 4'b0001 << offset;
            writedata  = {24'd0, rt_data[7:0]} << {offset, 3'b000};
         end
         SH: begin
            if (offset[0]) begin
               misaligned = 1'b1;
            end else if (offset[1]) begin
               byteenable = 4'b1100;
               writedata  = {rt_data[15:0], 16'd0};
            end else begin
               byteenable = 4'b0011;
               writedata  = {16'd0, rt_data[15:0]};
            end
         end
         SW: begin
            if (offset != 2'd0) begin
               misaligned = 1'b1;
            end else begin
               byteenable = BE_ALL;
               writedata  = rt_data;
            end
         end
         SWL: begin
            byteenable = BE_ALL >> (2'd3 - offset);
            writedata  = rt_data >> {(2'd3 - offset), 3'b000};
         end
         SWR: begin
            byteenable = BE_ALL << offset;
            writedata  = rt_data << {offset, 3'b000};
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store request, drives a single write on the
// little-endian data bus, holds it while the bus stalls and reports a
// one-cycle done or fault pulse. All outputs come straight from flops.
module store_unit
   import cpu_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 32'd0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] mem_address,
   output logic        mem_write,
   output logic [3:0]  mem_byteenable,
   output logic [31:0] mem_writedata,
   input  logic        mem_waitrequest
);

   // The counter counts stalled cycles already spent, so the abort fires
   // on the stalled cycle that would bring it up to WAIT_LIMIT.
   localparam logic        TIMEOUT_EN = (WAIT_LIMIT != 32'd0);
   localparam logic [31:0] LIMIT_M1   = (WAIT_LIMIT == 32'd0) ? 32'd0 : (WAIT_LIMIT - 32'd1);

   store_state_t state_r, state_s;
   logic         busy_r, busy_s;
   logic         done_r, done_s;
   logic         fault_r, fault_s;
   logic         write_r, write_s;
   logic [31:0]  address_r, address_s;
   logic [3:0]   be_r, be_s;
   logic [31:0]  wdata_r, wdata_s;
   logic [31:0]  count_r, count_s;

   logic [3:0]   align_be_s;
   logic [31:0]  align_wdata_s;
   logic         align_mis_s;
   logic         align_ill_s;
   logic         timeout_hit_s;

   store_lane_align u_align (
      .op         (op),
      .offset     (addr[1:0]),
      .rt_data    (rt_data),
      .byteenable (align_be_s),
      .writedata  (align_wdata_s),
      .misaligned (align_mis_s),
      .illegal    (align_ill_s)
   );

   // Stall budget exhausted on this cycle while the bus is still stalling.
   always_comb begin
      if (TIMEOUT_EN && mem_waitrequest && (count_r == LIMIT_M1)) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Next-state and next-output logic; pulses default low, bus holds.
   always_comb begin
      state_s   = state_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      fault_s   = 1'b0;
      write_s   = write_r;
      address_s = address_r;
      be_s      = be_r;
      wdata_s   = wdata_r;
      count_s   = count_r;
      case (state_r)
         IDLE: begin
            count_s = 32'd0;
            if (start) begin
               busy_s = 1'b1;
               if (align_mis_s || align_ill_s) begin
                  state_s   = RESP;
                  fault_s   = 1'b1;
                  write_s   = 1'b0;
                  address_s = 32'd0;
                  be_s      = BE_NONE;
                  wdata_s   = 32'd0;
               end else begin
                  state_s   = WRITE;
                  write_s   = 1'b1;
                  address_s = {addr[31:2], 2'b00};
                  be_s      = align_be_s;
                  wdata_s   = align_wdata_s;
               end
            end else begin
               busy_s    = 1'b0;
               write_s   = 1'b0;
               address_s = 32'd0;
               be_s      = BE_NONE;
               wdata_s   = 32'd0;
            end
         end
         WRITE: begin
            if (!mem_waitrequest || timeout_hit_s) begin
               state_s   = RESP;
               done_s    = !mem_waitrequest;
               fault_s   = mem_waitrequest;
               write_s   = 1'b0;
               address_s = 32'd0;
               be_s      = BE_NONE;
               wdata_s   = 32'd0;
               count_s   = 32'd0;
            end else begin
               count_s = count_r + 32'd1;
            end
         end
         RESP: begin
            state_s   = IDLE;
            busy_s    = 1'b0;
            write_s   = 1'b0;
            address_s = 32'd0;
            be_s      = BE_NONE;
            wdata_s   = 32'd0;
            count_s   = 32'd0;
         end
         default: begin
            state_s   = IDLE;
            busy_s    = 1'b0;
            write_s   = 1'b0;
            address_s = 32'd0;
            be_s      = BE_NONE;
            wdata_s   = 32'd0;
            count_s   = 32'd0;
         end
      endcase
   end

   // State and registered outputs; reset clears the bus immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         fault_r   <= 1'b0;
         write_r   <= 1'b0;
         address_r <= 32'd0;
         be_r      <= BE_NONE;
         wdata_r   <= 32'd0;
         count_r   <= 32'd0;
      end else begin
         state_r   <= state_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         fault_r   <= fault_s;
         write_r   <= write_s;
         address_r <= address_s;
         be_r      <= be_s;
         wdata_r   <= wdata_s;
         count_r   <= count_s;
      end
   end

   assign busy           = busy_r;
   assign done           = done_r;
   assign fault          = fault_r;
   assign mem_write      = write_r;
   assign mem_address    = address_r;
   assign mem_byteenable = be_r;
   assign mem_writedata  = wdata_r;

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit. Two instances share the
// stimulus: one with the timeout disabled, one with WAIT_LIMIT=4.
module tb_store_unit;
   import cpu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] rt_data;
   logic        waitreq;

   logic        busy, done, fault, mem_write;
   logic [31:0] mem_address, mem_writedata;
   logic [3:0]  mem_byteenable;

   logic        to_busy, to_done, to_fault, to_write;
   logic [31:0] to_address, to_writedata;
   logic [3:0]  to_byteenable;

   int n_checks = 0;
   int n_fail   = 0;

   store_unit dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .op              (op),
      .addr            (addr),
      .rt_data         (rt_data),
      .busy            (busy),
      .done            (done),
      .fault           (fault),
      .mem_address     (mem_address),
      .mem_write       (mem_write),
      .mem_byteenable  (mem_byteenable),
      .mem_writedata   (mem_writedata),
      .mem_waitrequest (waitreq)
   );

   store_unit #(.WAIT_LIMIT(32'd4)) dut_to (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .op              (op),
      .addr            (addr),
      .rt_data         (rt_data),
      .busy            (to_busy),
      .done            (to_done),
      .fault           (to_fault),
      .mem_address     (to_address),
      .mem_write       (to_write),
      .mem_byteenable  (to_byteenable),
      .mem_writedata   (to_writedata),
      .mem_waitrequest (waitreq)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns at the negedge after acceptance.
   task automatic do_start(input logic [2:0] op_i, input logic [31:0] addr_i, input logic [31:0] rt_i);
      op      = op_i;
      addr    = addr_i;
      rt_data = rt_i;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      op      = 3'd0;
      addr    = 32'hFFFF_FFFF;
      rt_data = 32'h0BAD_F00D;
   endtask

   // Unstalled store: one write cycle, then done, then idle.
   task automatic run_write(input string tag, input logic [2:0] op_i, input logic [31:0] addr_i,
                            input logic [31:0] rt_i, input logic [3:0] be_e, input logic [31:0] wd_e);
      do_start(op_i, addr_i, rt_i);
      check({tag, ".write"}, {31'd0, mem_write}, 32'd1);
      check({tag, ".busy"},  {31'd0, busy}, 32'd1);
      check({tag, ".addr"},  mem_address, {addr_i[31:2], 2'b00});
      check({tag, ".be"},    {28'd0, mem_byteenable}, {28'd0, be_e});
      check({tag, ".wdata"}, mem_writedata, wd_e);
      @(negedge clk);
      check({tag, ".done"},  {31'd0, done}, 32'd1);
      check({tag, ".wr_off"}, {31'd0, mem_write}, 32'd0);
      check({tag, ".fault"}, {31'd0, fault}, 32'd0);
      @(negedge clk);
      check({tag, ".done_end"}, {31'd0, done}, 32'd0);
      check({tag, ".idle"},     {31'd0, busy}, 32'd0);
   endtask

   // Rejected store: fault in the cycle after start, no bus write.
   task automatic run_fault(input string tag, input logic [2:0] op_i, input logic [31:0] addr_i);
      do_start(op_i, addr_i, 32'h1234_5678);
      check({tag, ".fault"}, {31'd0, fault}, 32'd1);
      check({tag, ".busy"},  {31'd0, busy}, 32'd1);
      check({tag, ".write"}, {31'd0, mem_write}, 32'd0);
      check({tag, ".done"},  {31'd0, done}, 32'd0);
      @(negedge clk);
      check({tag, ".fault_end"}, {31'd0, fault}, 32'd0);
      check({tag, ".idle"},      {31'd0, busy}, 32'd0);
      check({tag, ".nowrite"},   {31'd0, mem_write}, 32'd0);
   endtask

   // Directed sequence.
   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      op      = 3'd0;
      addr    = 32'd0;
      rt_data = 32'd0;
      waitreq = 1'b0;
      repeat (2) @(negedge clk);

      check("rst.busy",  {31'd0, busy}, 32'd0);
      check("rst.done",  {31'd0, done}, 32'd0);
      check("rst.fault", {31'd0, fault}, 32'd0);
      check("rst.write", {31'd0, mem_write}, 32'd0);
      check("rst.addr",  mem_address, 32'd0);
      check("rst.be",    {28'd0, mem_byteenable}, 32'd0);
      check("rst.wdata", mem_writedata, 32'd0);
      check("rst.to_write", {31'd0, to_write}, 32'd0);
      check("rst.to_addr",  to_address, 32'd0);
      check("rst.to_be",    {28'd0, to_byteenable}, 32'd0);
      check("rst.to_wdata", to_writedata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_write("swl1",  SWL, 32'h0000_1001, 32'hAABB_CCDD, 4'b0011, 32'h0000_AABB);
      run_write("swr2",  SWR, 32'h0000_1002, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_0000);
      run_write("sb3",   SB,  32'h0000_1003, 32'hAABB_CCDD, 4'b1000, 32'hDD00_0000);
      run_write("sh2",   SH,  32'h0000_1002, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_0000);
      run_write("sh0",   SH,  32'h0000_1000, 32'hAABB_CCDD, 4'b0011, 32'h0000_CCDD);
      run_write("sb1",   SB,  32'h0000_1001, 32'hAABB_CCDD, 4'b0010, 32'h0000_DD00);
      run_write("sw0",   SW,  32'h0000_1004, 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD);
      run_write("swl2",  SWL, 32'h0000_1002, 32'hAABB_CCDD, 4'b0111, 32'h00AA_BBCC);
      run_write("swr1",  SWR, 32'h0000_1001, 32'hAABB_CCDD, 4'b1110, 32'hBBCC_DD00);
      run_write("swr0",  SWR, 32'h0000_1000, 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD);

      run_fault("sw_mis", SW, 32'h0000_1001);
      run_fault("sh_mis", SH, 32'h0000_1003);
      run_fault("op7",    3'd7, 32'h0000_1000);

      // Stalled write of three cycles with a second start while busy.
      waitreq = 1'b1;
      do_start(SW, 32'h0000_2000, 32'h1234_5678);
      for (int i = 0; i < 4; i++) begin
         check("stall.write", {31'd0, mem_write}, 32'd1);
         check("stall.addr",  mem_address, 32'h0000_2000);
         check("stall.be",    {28'd0, mem_byteenable}, 32'h0000_000F);
         check("stall.wdata", mem_writedata, 32'h1234_5678);
         check("stall.done",  {31'd0, done}, 32'd0);
         if (i == 0) begin
            op      = SB;
            addr    = 32'h0000_3000;
            rt_data = 32'h0000_0055;
            start   = 1'b1;
         end else begin
            start   = 1'b0;
         end
         if (i == 3) begin
            waitreq = 1'b0;
         end else begin
            waitreq = 1'b1;
         end
         @(negedge clk);
      end
      check("stall.done_pulse", {31'd0, done}, 32'd1);
      check("stall.wr_off",     {31'd0, mem_write}, 32'd0);
      @(negedge clk);
      check("stall.done_end", {31'd0, done}, 32'd0);
      check("stall.idle",     {31'd0, busy}, 32'd0);
      check("stall.no_extra", {31'd0, mem_write}, 32'd0);
      @(negedge clk);
      check("stall.no_extra2", {31'd0, mem_write}, 32'd0);

      // Bus stuck: the WAIT_LIMIT=4 instance must abort with a fault.
      waitreq = 1'b1;
      do_start(SW, 32'h0000_4000, 32'hCAFE_BABE);
      for (int i = 0; i < 4; i++) begin
         check("tmo.write", {31'd0, to_write}, 32'd1);
         check("tmo.fault", {31'd0, to_fault}, 32'd0);
         @(negedge clk);
      end
      check("tmo.wr_off",      {31'd0, to_write}, 32'd0);
      check("tmo.fault_pulse", {31'd0, to_fault}, 32'd1);
      check("tmo.no_done",     {31'd0, to_done}, 32'd0);
      check("tmo.busy",        {31'd0, to_busy}, 32'd1);
      @(negedge clk);
      check("tmo.fault_end", {31'd0, to_fault}, 32'd0);
      check("tmo.no_done2",  {31'd0, to_done}, 32'd0);
      check("tmo.idle",      {31'd0, to_busy}, 32'd0);
      check("nolimit.still_writing", {31'd0, mem_write}, 32'd1);

      // Asynchronous reset in the middle of a write.
      #2;
      reset = 1'b1;
      #1;
      check("arst.write", {31'd0, mem_write}, 32'd0);
      check("arst.busy",  {31'd0, busy}, 32'd0);
      check("arst.addr",  mem_address, 32'd0);
      check("arst.be",    {28'd0, mem_byteenable}, 32'd0);
      check("arst.wdata", mem_writedata, 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      waitreq = 1'b0;
      @(negedge clk);
      check("arst.no_done",  {31'd0, done}, 32'd0);
      check("arst.no_fault", {31'd0, fault}, 32'd0);
      check("arst.idle",     {31'd0, busy}, 32'd0);
      run_write("swl3", SWL, 32'h0000_5003, 32'h1122_3344, 4'b1111, 32'h1122_3344);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
